// File: rtl/contador_pkg.sv
// Shared constants and types for the universal counter.
// Saturation instead of wrap is selected with CONTADOR_SATURACAO_EN.
package contador_pkg;

    localparam int CONT_WIDTH_DEF = 4;

    localparam logic CONT_UP   = 1'b1;
    localparam logic CONT_DOWN = 1'b0;

    typedef enum logic [2:0] {
        ACAO_HOLD,
        ACAO_PRESET,
        ACAO_LOAD,
        ACAO_INC,
        ACAO_DEC
    } acao_e;

endpackage

// File: rtl/contador_prox_estado.sv
// Next-count arithmetic: priority decode, clamp, wrap or saturate.
// CONTADOR_SATURACAO_EN turns end-of-range wrap into saturation.
module contador_prox_estado
    import contador_pkg::*;
#(
    parameter int WIDTH   = CONT_WIDTH_DEF,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             preset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] q_next
);

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    acao_e            acao;
    logic [WIDTH-1:0] d_clamp;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;

    always_comb begin
        acao = ACAO_HOLD;
        priority case (1'b1)
            !preset_n:                     acao = ACAO_PRESET;
            load:                          acao = ACAO_LOAD;
            enable && up_down == CONT_UP:  acao = ACAO_INC;
            enable:                        acao = ACAO_DEC;
            default:                       acao = ACAO_HOLD;
        endcase
    end

    assign d_clamp = ({1'b0, d} >= MOD_EXT) ? Q_MAX : d;

    // Out-of-range q is unreachable; still folded back into range.
    always_comb begin
        q_inc = q + ONE;
        if (q >= Q_MAX) begin
`ifdef CONTADOR_SATURACAO_EN
            q_inc = Q_MAX;
`else
            q_inc = ZERO;
`endif
        end
    end

    always_comb begin
        q_dec = q - ONE;
        if (q == ZERO) begin
`ifdef CONTADOR_SATURACAO_EN
            q_dec = ZERO;
`else
            q_dec = Q_MAX;
`endif
        end else if (q > Q_MAX) begin
            q_dec = Q_MAX;
        end
    end

    always_comb begin
        q_next = q;
        unique case (acao)
            ACAO_PRESET: q_next = Q_MAX;
            ACAO_LOAD:   q_next = d_clamp;
            ACAO_INC:    q_next = q_inc;
            ACAO_DEC:    q_next = q_dec;
            default:     q_next = q;
        endcase
    end

endmodule

// File: rtl/contador_universal.sv
// Universal modulo-N up/down counter with preset, load and cascade tc.
// Build with CONTADOR_SATURACAO_EN to saturate instead of wrapping.
module contador_universal
    import contador_pkg::*;
#(
    parameter int WIDTH   = CONT_WIDTH_DEF,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             preset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] Q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    contador_prox_estado #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_prox (
        .q        (q_q),
        .preset_n (preset),
        .load     (load),
        .d        (d),
        .enable   (enable),
        .up_down  (up_down),
        .q_next   (q_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Zero-latency terminal count so stages cascade without skew.
    always_comb begin
        tc = 1'b0;
        if (enable) begin
            if (up_down == CONT_UP) begin
                tc = (q_q == Q_MAX);
            end else begin
                tc = (q_q == '0);
            end
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_contador_universal.sv
// Directed scoreboard bench for contador_universal (MODULUS=10).
// Saturating expectations are used when CONTADOR_SATURACAO_EN is set.
module tb_contador_universal;

    typedef struct {
        string      name;
        bit         sel;
        logic [7:0] q;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   n_cmp = 0;
    int   n_err = 0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       preset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;
    logic       enable = 1'b1;
    logic       up_down = 1'b1;
    logic [3:0] q_out;
    logic       tc_out;

    logic       c_reset = 1'b0;
    logic       c_en = 1'b0;
    logic       c_ud = 1'b1;
    logic [3:0] lo_q;
    logic [3:0] hi_q;
    logic       lo_tc;
    logic       hi_tc;

    always #5 clock = ~clock;

    contador_universal #(.WIDTH(4), .MODULUS(10)) dut (
        .clock   (clock),
        .reset   (reset),
        .preset  (preset),
        .load    (load),
        .d       (d),
        .enable  (enable),
        .up_down (up_down),
        .Q       (q_out),
        .tc      (tc_out)
    );

    contador_universal #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clock   (clock),
        .reset   (c_reset),
        .preset  (1'b1),
        .load    (1'b0),
        .d       (4'd0),
        .enable  (c_en),
        .up_down (c_ud),
        .Q       (lo_q),
        .tc      (lo_tc)
    );

    contador_universal #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clock   (clock),
        .reset   (c_reset),
        .preset  (1'b1),
        .load    (1'b0),
        .d       (4'd0),
        .enable  (lo_tc),
        .up_down (c_ud),
        .Q       (hi_q),
        .tc      (hi_tc)
    );

    // Monitor: drains the scoreboard at each falling edge or on request.
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       at;
        forever begin
            @(negedge clock or sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    aq = {hi_q, lo_q};
                    at = hi_tc;
                end else begin
                    aq = {4'h0, q_out};
                    at = tc_out;
                end
                n_cmp++;
                if (aq !== e.q || at !== e.tc) begin
                    n_err++;
                    $display("FAIL %s: got Q=%0h tc=%0b, expected Q=%0h tc=%0b",
                             e.name, aq, at, e.q, e.tc);
                end
            end
        end
    end

    task automatic push(input string nm, input bit sel, input int eq, input int et);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.q    = 8'(eq);
        e.tc   = (et != 0);
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input int pre, input int ld, input int dv,
                        input int en, input int ud, input int eq, input int et);
        preset  = (pre != 0);
        load    = (ld != 0);
        d       = 4'(dv);
        enable  = (en != 0);
        up_down = (ud != 0);
        @(posedge clock);
        push(nm, 1'b0, eq, et);
        @(negedge clock);
        #1;
    endtask

    task automatic now_check(input string nm, input bit sel, input int eq, input int et);
        #1;
        push(nm, sel, eq, et);
        -> sample_ev;
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        #2;
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

`ifdef CONTADOR_SATURACAO_EN
    int exp_up[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int exp_dn[3]   = '{0, 0, 0};
    int exp_dntc[3] = '{1, 1, 1};
    int sat_up[3]   = '{9, 9, 9};
    int sat_uptc[3] = '{1, 1, 1};
    int sat_dn[2]   = '{0, 0};
    int sat_dntc[2] = '{1, 1};
`else
    int exp_up[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_dn[3]   = '{9, 8, 7};
    int exp_dntc[3] = '{0, 0, 0};
    int sat_up[3]   = '{9, 0, 1};
    int sat_uptc[3] = '{1, 0, 0};
    int sat_dn[2]   = '{0, 9};
    int sat_dntc[2] = '{1, 0};
`endif

    initial begin
        #3;
        now_check("rst_q0", 1'b0, 0, 0);
        up_down = 1'b0;
        now_check("rst_tc_down", 1'b0, 0, 1);
        up_down = 1'b1;
        @(negedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step($sformatf("up_%0d", i), 1, 0, 0, 1, 1, exp_up[i], exp_up[i] == 9);
        end

        reset   = 1'b0;
        up_down = 1'b0;
        now_check("dn_start", 1'b0, 0, 1);
        @(negedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("dn_%0d", i), 1, 0, 0, 1, 0, exp_dn[i], exp_dntc[i]);
        end

        step("load_clamp13", 1, 1, 13, 0, 1, 9, 0);
        step("preset_over_load", 0, 1, 2, 0, 1, 9, 0);
        step("load_3", 1, 1, 3, 0, 1, 3, 0);
        step("load_clamp15", 1, 1, 15, 0, 1, 9, 0);
        step("load_clamp10", 1, 1, 10, 0, 1, 9, 0);
        step("hold_tc_gated", 1, 0, 0, 0, 1, 9, 0);
        step("load_0", 1, 1, 0, 0, 0, 0, 0);
        step("hold_zero", 1, 0, 0, 0, 0, 0, 0);
        step("load_over_en", 1, 1, 4, 1, 1, 4, 0);
        step("dir_up", 1, 0, 0, 1, 1, 5, 0);
        step("dir_down", 1, 0, 0, 1, 0, 4, 0);
        step("dir_up2", 1, 0, 0, 1, 1, 5, 0);
        step("preset_over_en", 0, 0, 0, 1, 1, 9, 1);

        step("load_8", 1, 1, 8, 0, 1, 8, 0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("end_up_%0d", i), 1, 0, 0, 1, 1, sat_up[i], sat_uptc[i]);
        end
        step("load_1", 1, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step($sformatf("end_dn_%0d", i), 1, 0, 0, 1, 0, sat_dn[i], sat_dntc[i]);
        end

        step("load_0b", 1, 1, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step($sformatf("pre_rst_%0d", i), 1, 0, 0, 1, 1, i, 0);
        end
        reset = 1'b0;
        now_check("async_rst", 1'b0, 0, 0);
        step("rst_hold_load", 1, 1, 5, 1, 1, 0, 0);
        step("rst_hold_preset", 0, 0, 0, 1, 1, 0, 0);
        preset  = 1'b1;
        up_down = 1'b0;
        now_check("rst_tc_dn2", 1'b0, 0, 1);
        up_down = 1'b1;
        reset   = 1'b1;
        step("rst_resume", 1, 0, 0, 1, 1, 1, 0);

        c_reset = 1'b1;
        c_en    = 1'b1;
        repeat (10) @(posedge clock);
        now_check("cascade_10", 1'b1, 8'h10, 0);
        repeat (15) @(posedge clock);
        now_check("cascade_25", 1'b1, 8'h25, 0);
        @(negedge clock);
        #1;
        c_en = 1'b0;
        repeat (3) @(posedge clock);
        now_check("cascade_hold", 1'b1, 8'h25, 0);

        @(negedge clock);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
